// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encodings, reset and
// exception vectors, and the payload handed from fetch to decode.
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_VECTOR = 32'hbfc0_0000;
  localparam logic [31:0] EXC_VECTOR   = 32'hbfc0_0380;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } if_payload_t;

endpackage

// File: rtl/ifetch_if.sv
// SRAM-like instruction port: the fetch stage drives the request side,
// and the memory drives the accept, data-valid and read-data side.
interface ifetch_if;

  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata
  );

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata
  );

endinterface

// File: rtl/ifetch.sv
// Instruction-fetch stage: one outstanding SRAM-like read, stalls the PC while
// busy, drops responses made stale by a flush, and holds a one-entry output slot.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_VECTOR
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] npc,
  input  logic        flush,
  input  logic        id_allowin,
  output logic        if_stall,
  ifetch_if.master    bus,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_adel
);

  fetch_state_t state, state_next;
  logic         cancel, cancel_next;
  logic [31:0]  req_pc;
  if_payload_t  entry, load_data;
  logic         load;
  logic         capture;
  logic         slot_free;

  // Next-state and bus outputs; capture is gated by resetn so the PC stays stalled in reset.
  always_comb begin
    state_next    = state;
    cancel_next   = cancel;
    load          = 1'b0;
    load_data     = '0;
    capture       = 1'b0;
    bus.inst_req  = 1'b0;
    bus.inst_addr = req_pc;
    slot_free     = !if_valid || id_allowin;

    case (state)
      IDLE: begin
        if (resetn && !flush && slot_free) begin
          capture = 1'b1;
          if (npc[1:0] != 2'b00) begin
            load      = 1'b1;
            load_data = '{pc: npc, inst: 32'h0, adel: 1'b1};
          end else begin
            state_next = REQ;
          end
        end
      end
      REQ: begin
        bus.inst_req = resetn;
        if (bus.inst_addr_ok) state_next  = WAIT;
        if (flush)            cancel_next = 1'b1;
      end
      WAIT: begin
        if (bus.inst_data_ok) begin
          state_next  = IDLE;
          cancel_next = 1'b0;
          if (!(cancel || flush)) begin
            load      = 1'b1;
            load_data = '{pc: req_pc, inst: bus.inst_rdata, adel: 1'b0};
          end
        end else if (flush) begin
          cancel_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    if_stall = !capture;
  end

  // A load and a flush never coincide, so flush only needs to win over consumption.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      cancel   <= 1'b0;
      req_pc   <= RESET_PC;
      if_valid <= 1'b0;
      entry    <= '{pc: RESET_PC, inst: 32'h0, adel: 1'b0};
    end else begin
      state  <= state_next;
      cancel <= cancel_next;
      if (capture) req_pc <= npc;
      if (flush)           if_valid <= 1'b0;
      else if (load)       if_valid <= 1'b1;
      else if (id_allowin) if_valid <= 1'b0;
      if (load) entry <= load_data;
    end
  end

  assign if_pc   = entry.pc;
  assign if_inst = entry.inst;
  assign if_adel = entry.adel;

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed scenarios then randomized traffic,
// all compared cycle by cycle against a transaction-level model of the stage.
module tb_ifetch;
  import ifetch_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] npc;
  logic        flush;
  logic        id_allowin;
  logic        if_stall;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_adel;

  always #5 clk = ~clk;

  ifetch_if bus ();

  ifetch #(.RESET_PC(32'hbfc0_0000)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .npc        (npc),
    .flush      (flush),
    .id_allowin (id_allowin),
    .if_stall   (if_stall),
    .bus        (bus),
    .if_valid   (if_valid),
    .if_pc      (if_pc),
    .if_inst    (if_inst),
    .if_adel    (if_adel)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: one outstanding fetch record plus the decode-facing entry.
  bit          m_known    = 1'b0;
  bit          m_busy     = 1'b0;
  bit          m_accepted = 1'b0;
  bit          m_kill     = 1'b0;
  logic [31:0] m_addr     = 32'h0;
  bit          m_valid    = 1'b0;
  logic [31:0] m_pc       = 32'h0;
  logic [31:0] m_inst     = 32'h0;
  bit          m_adel     = 1'b0;
  logic [31:0] fetch_pc   = 32'hbfc0_0000;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model at the edge.
  task automatic applyStimulus(input logic rst_v, input logic [31:0] npc_v, input logic flush_v,
                               input logic allow_v, input logic aok_en, input logic dok_en,
                               input logic [31:0] rdata_v);
    logic        exp_req, take, aok, dok, load, load_adel;
    logic [31:0] load_pc, load_inst;
    @(negedge clk);
    exp_req = rst_v && m_known && m_busy && !m_accepted;
    aok     = aok_en && exp_req;
    dok     = rst_v && dok_en && m_known && m_busy && m_accepted;
    take    = rst_v && m_known && !m_busy && !flush_v && (!m_valid || allow_v);
    resetn           = rst_v;
    npc              = npc_v;
    flush            = flush_v;
    id_allowin       = allow_v;
    bus.inst_addr_ok = aok;
    bus.inst_data_ok = dok;
    bus.inst_rdata   = rdata_v;
    #1;
    checkOutput("inst_req", {31'h0, bus.inst_req}, {31'h0, exp_req});
    if (exp_req) checkOutput("inst_addr", bus.inst_addr, m_addr);
    checkOutput("if_stall", {31'h0, if_stall}, {31'h0, !take});
    if (m_known) begin
      checkOutput("if_valid", {31'h0, if_valid}, {31'h0, m_valid});
      checkOutput("if_pc", if_pc, m_pc);
      checkOutput("if_inst", if_inst, m_inst);
      checkOutput("if_adel", {31'h0, if_adel}, {31'h0, m_adel});
    end
    @(posedge clk);
    if (!rst_v) begin
      m_known    = 1'b1;
      m_busy     = 1'b0;
      m_accepted = 1'b0;
      m_kill     = 1'b0;
      m_addr     = RESET_VECTOR;
      m_valid    = 1'b0;
      m_pc       = RESET_VECTOR;
      m_inst     = 32'h0;
      m_adel     = 1'b0;
      fetch_pc   = RESET_VECTOR;
    end else begin
      load      = 1'b0;
      load_pc   = 32'h0;
      load_inst = 32'h0;
      load_adel = 1'b0;
      if (m_busy && !m_accepted) begin
        if (aok)     m_accepted = 1'b1;
        if (flush_v) m_kill     = 1'b1;
      end else if (m_busy) begin
        if (dok) begin
          if (!(m_kill || flush_v)) begin
            load      = 1'b1;
            load_pc   = m_addr;
            load_inst = rdata_v;
          end
          m_busy = 1'b0;
          m_kill = 1'b0;
        end else if (flush_v) begin
          m_kill = 1'b1;
        end
      end else if (take) begin
        fetch_pc = {npc_v[31:2], 2'b00} + 32'd4;
        if (npc_v[1:0] != 2'b00) begin
          load      = 1'b1;
          load_pc   = npc_v;
          load_adel = 1'b1;
        end else begin
          m_busy     = 1'b1;
          m_accepted = 1'b0;
          m_kill     = 1'b0;
          m_addr     = npc_v;
        end
      end
      if (flush_v)      m_valid = 1'b0;
      else if (load)    m_valid = 1'b1;
      else if (allow_v) m_valid = 1'b0;
      if (load) begin
        m_pc   = load_pc;
        m_inst = load_inst;
        m_adel = load_adel;
      end
    end
    #1;
  endtask

  initial begin
    logic        r_flush;
    logic [31:0] r_npc;
    resetn           = 1'b0;
    npc              = RESET_VECTOR;
    flush            = 1'b0;
    id_allowin       = 1'b1;
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b0;
    bus.inst_rdata   = 32'h0;

    repeat (2) applyStimulus(1'b0, RESET_VECTOR, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("reset if_valid", {31'h0, if_valid}, 32'h0);
    checkOutput("reset if_pc", if_pc, 32'hbfc0_0000);

    // Back-to-back fetches on a zero-wait bus.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, fetch_pc, 1'b0, 1'b1, 1'b1, 1'b1, 32'h2408_0000 + i);
      if (i == 2) begin
        checkOutput("b2b first pc", if_pc, 32'hbfc0_0000);
        checkOutput("b2b first inst", if_inst, 32'h2408_0002);
      end
      if (i == 5) begin
        checkOutput("b2b second pc", if_pc, 32'hbfc0_0004);
        checkOutput("b2b second inst", if_inst, 32'h2408_0005);
      end
    end

    // Flush while waiting for data: the response must be dropped.
    applyStimulus(1'b1, fetch_pc, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, fetch_pc, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, EXC_VECTOR, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, EXC_VECTOR, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1234_5678);
    checkOutput("flush wait valid", {31'h0, if_valid}, 32'h0);
    applyStimulus(1'b1, EXC_VECTOR, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, fetch_pc, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, fetch_pc, 1'b0, 1'b1, 1'b0, 1'b1, 32'h4000_0001);
    checkOutput("redirect pc", if_pc, 32'hbfc0_0380);

    // Flush coinciding with addr_ok, then a clean fetch must still complete.
    applyStimulus(1'b1, fetch_pc, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'hbfc0_0400, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'hbfc0_0400, 1'b0, 1'b1, 1'b0, 1'b1, 32'hdead_beef);
    checkOutput("flush aok valid", {31'h0, if_valid}, 32'h0);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 32'hbfc0_0400, 1'b0, 1'b1, 1'b1, 1'b1, 32'h3c1d_0000);
    checkOutput("after cancel valid", {31'h0, if_valid}, 32'h1);
    checkOutput("after cancel pc", if_pc, 32'hbfc0_0400);

    // Misaligned npc produces an adel entry without a bus request.
    applyStimulus(1'b1, 32'hbfc0_0102, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("adel valid", {31'h0, if_valid}, 32'h1);
    checkOutput("adel flag", {31'h0, if_adel}, 32'h1);
    checkOutput("adel pc", if_pc, 32'hbfc0_0102);
    checkOutput("adel inst", if_inst, 32'h0);

    // Backpressure: the entry is held and nothing is captured.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 32'hbfc0_0200, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
      checkOutput("held pc", if_pc, 32'hbfc0_0102);
    end
    applyStimulus(1'b1, 32'hbfc0_0200, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0);
    applyStimulus(1'b1, fetch_pc, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0);
    applyStimulus(1'b1, fetch_pc, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0800_0010);
    checkOutput("post bp pc", if_pc, 32'hbfc0_0200);

    // Randomized traffic with random bus latency, flushes, stalls and resets.
    for (int i = 0; i < 600; i++) begin
      r_flush = ($urandom % 8) == 0;
      if (($urandom % 16) == 0)
        r_npc = {fetch_pc[31:2], 2'($urandom_range(1, 3))};
      else if (r_flush)
        r_npc = $urandom & 32'hffff_fffc;
      else
        r_npc = fetch_pc;
      applyStimulus(($urandom % 64) != 0, r_npc, r_flush, ($urandom % 4) != 0,
                    1'($urandom % 2), 1'($urandom % 2), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
